// File: rtl/decode_stage.sv
// RV32I decode stage: field extraction, immediate generation, 32-entry register file and a valid/ready output register.
// Optional macro DECODE_BYPASS_EN forwards a same-edge write-back into the captured operands.
module decode_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [31:0]     instr,
   input  logic            wb_en,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [6:0]      opcode,
   output logic [2:0]      funct3,
   output logic            modbit,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] rs1,
   output logic [XLEN-1:0] rs2,
   output logic [4:0]      rd_addr,
   output logic            illegal
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   logic [XLEN-1:0] regs [32];
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            accept;

   function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] ins);
      logic signed [31:0] v;
      case (ins[6:0])
         OP_IMM, OP_LOAD, OP_JALR: v = {{20{ins[31]}}, ins[31:20]};
         OP_STORE:                 v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         OP_BRANCH:                v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         OP_LUI, OP_AUIPC:         v = {ins[31:12], 12'b0};
         OP_JAL:                   v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default:                  v = '0;
      endcase
      return XLEN'(v);
   endfunction

   function automatic logic op_legal(input logic [6:0] op);
      case (op)
         OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE,
         OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: return 1'b1;
         default:                             return 1'b0;
      endcase
   endfunction

   function automatic logic mod_gen(input logic [31:0] ins);
      return ((ins[6:0] == OP_R) || (ins[6:0] == OP_IMM && ins[14:12] == 3'b101)) ? ins[30] : 1'b0;
   endfunction

   assign instr_ready = !out_valid || out_ready;
   assign accept      = instr_valid && instr_ready;

   // Register file: x0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wb_en && wb_addr != 5'd0) begin
         regs[wb_addr] <= wb_data;
      end
   end

   always_comb begin
      rs1_val = (instr[19:15] == 5'd0) ? '0 : regs[instr[19:15]];
      rs2_val = (instr[24:20] == 5'd0) ? '0 : regs[instr[24:20]];
`ifdef DECODE_BYPASS_EN
      if (wb_en && wb_addr != 5'd0 && wb_addr == instr[19:15]) rs1_val = wb_data;
      if (wb_en && wb_addr != 5'd0 && wb_addr == instr[24:20]) rs2_val = wb_data;
`endif
   end

   // Output stage: captured on acceptance, held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         opcode    <= '0;
         funct3    <= '0;
         modbit    <= 1'b0;
         imm       <= '0;
         rs1       <= '0;
         rs2       <= '0;
         rd_addr   <= '0;
         illegal   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         opcode    <= instr[6:0];
         funct3    <= instr[14:12];
         modbit    <= mod_gen(instr);
         imm       <= imm_gen(instr);
         rs1       <= rs1_val;
         rs2       <= rs2_val;
         rd_addr   <= instr[11:7];
         illegal   <= !op_legal(instr[6:0]);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data width of registers, immediates and operands.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, active on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port instr_valid, input, 1 bit: an instruction word is offered.
REQ-005 The block SHALL have port instr_ready, output, 1 bit: the stage accepts the offered instruction.
REQ-006 The block SHALL have port instr, input, 32 bits: the RV32I instruction word.
REQ-007 The block SHALL have port wb_en, input, 1 bit: register-file write enable.
REQ-008 The block SHALL have port wb_addr, input, 5 bits: register-file write address.
REQ-009 The block SHALL have port wb_data, input, XLEN bits: register-file write data.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the decoded operands are valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the ALU stage consumes the outputs.
REQ-012 The block SHALL have ports opcode (7 bits), funct3 (3 bits), modbit (1 bit), imm (XLEN bits), rs1 (XLEN bits), rs2 (XLEN bits), rd_addr (5 bits) and illegal (1 bit), all outputs and all registered.

Function
REQ-013 instr_ready SHALL equal !out_valid || out_ready, combinationally.
REQ-014 An instruction SHALL be accepted on a rising edge where instr_valid && instr_ready; all outputs SHALL update on that edge (1-cycle latency) and out_valid SHALL be set to 1.
REQ-015 out_valid SHALL clear on an edge where out_valid && out_ready && !instr_valid; while out_valid && !out_ready, all outputs SHALL hold stable.
REQ-016 opcode, funct3 and rd_addr SHALL be taken from instr[6:0], instr[14:12] and instr[11:7] respectively.
REQ-017 modbit SHALL be instr[30] for opcode 0110011, and for opcode 0010011 with funct3=101; otherwise it SHALL be 0.
REQ-018 imm SHALL be sign-extended according to opcode:
- I-type (0010011, 0000011, 1100111): instr[31:20]
- S-type (0100011): {instr[31:25], instr[11:7]}
- B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- U-type (0110111, 0010111): {instr[31:12], 12'b0}
- J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- R-type (0110011): 0
REQ-019 Any other opcode SHALL set illegal=1 with imm=0; the instruction SHALL still flow through the handshake. Otherwise illegal SHALL be 0.
REQ-020 The block SHALL contain a 32 x XLEN register file read at instr[19:15] (to rs1) and instr[24:20] (to rs2) at acceptance.
REQ-021 Register x0 SHALL always read as 0, and writes to x0 SHALL be discarded.
REQ-022 A write with wb_en=1 SHALL update register file entry wb_addr on the rising edge, independent of the handshake state.
REQ-023 Operands SHALL be sampled only at acceptance; a write-back to a source register of an instruction already held SHALL NOT alter rs1 or rs2. Hazard avoidance is upstream's responsibility.

Reset
REQ-024 While rst_n=0, the block SHALL asynchronously force out_valid=0, illegal=0, modbit=0, opcode=0, funct3=0, rd_addr=0, imm=0, rs1=0 and rs2=0, and clear all 32 registers.
REQ-025 Reset asserted mid-stall SHALL discard the held instruction.
REQ-026 After reset, instr_ready SHALL be 1.

Configuration
REQ-027 With DECODE_BYPASS_EN defined, if wb_en=1 and wb_addr≠0 equals a source address on the accept edge, the captured operand SHALL be wb_data.
REQ-028 Without DECODE_BYPASS_EN defined, the captured operand on that same edge SHALL be the pre-write register value.

Verification
REQ-029 The bench SHALL cover: write x1=150, x2=50, then accept 0x002080B3 (add x1,x1,x2) -> next cycle opcode=0110011, funct3=000, modbit=0, rs1=150, rs2=50, rd_addr=1, imm=0.
REQ-030 The bench SHALL cover: accept 0x40208133 (sub) -> modbit=1; accept 0xFFF00093 (addi x1,x0,-1) -> imm=0xFFFFFFFF, rs1=0.
REQ-031 The bench SHALL cover: out_ready=0 with a second instruction offered -> instr_ready=0 and outputs unchanged for 3 cycles; out_ready=1 -> second instruction appears one cycle later.
REQ-032 The bench SHALL cover: wb_en=1, wb_addr=3, wb_data=7 on the same edge as accepting a read of x3 -> rs1=7 with DECODE_BYPASS_EN, the old value (0) without it.
REQ-033 The bench SHALL cover: instr=0xFFFFFFFF -> illegal=1, out_valid=1; write wb_addr=0, wb_data=5, then read x0 -> rs1=0.
REQ-034 The bench SHALL cover: rst_n pulsed low mid-stall -> out_valid=0 immediately, and all registers read 0 after reset.
